muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared widths, operation codes and FSM states for the iterative mul/div unit.
package muldiv_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply,
// restoring trial-subtract for divide. {hi, lo} is the working pair.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Compute both step flavours and select by operation class.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - d;
        hi_next = '0;
        lo_next = '0;
        if (is_div) begin
            if (shifted >= {1'b0, d}) begin
                hi_next = diff;
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = shifted[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit unsigned multiply/divide unit with register-file writeback.
module muldiv_unit #(
    parameter int WIDTH  = muldiv_pkg::WIDTH,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  operand_a,
    input  logic [WIDTH-1:0]  operand_b,
    input  logic [REG_AW-1:0] dest_reg,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_reg,
    output logic [WIDTH-1:0]  wb_data
);

    import muldiv_pkg::*;

    state_t            state, state_next;
    op_t               op_q;
    logic [WIDTH-1:0]  d_q, hi_q, lo_q, hi_n, lo_n;
    logic [5:0]        cnt_q;
    logic [REG_AW-1:0] wb_reg_q;
    logic [WIDTH-1:0]  wb_data_q;
    logic              accept, last, is_div;

    assign accept = start && !flush && (state != ST_RUN);
    // Count runs 0..31 for the iterations, then one extra RUN cycle at 32
    // latches the result, giving the fixed 33-edge start-to-done latency.
    assign last   = (cnt_q == 6'd32);
    assign is_div = (op_q == OP_DIVU) || (op_q == OP_REMU);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .hi      (hi_q),
        .lo      (lo_q),
        .d       (d_q),
        .hi_next (hi_n),
        .lo_next (lo_n)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic; flush beats start, and aborts a running operation.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_RUN;
            ST_RUN: begin
                if (flush)     state_next = ST_IDLE;
                else if (last) state_next = ST_DONE;
            end
            ST_DONE: state_next = accept ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand capture, iteration and result writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_MUL;
            d_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
        end else if (accept) begin
            op_q     <= op_t'(op);
            d_q      <= op[1] ? operand_b : operand_a;
            lo_q     <= op[1] ? operand_a : operand_b;
            hi_q     <= '0;
            cnt_q    <= '0;
            wb_reg_q <= dest_reg;
        end else if (state == ST_RUN && !flush) begin
            if (!last) begin
                hi_q  <= hi_n;
                lo_q  <= lo_n;
                cnt_q <= cnt_q + 6'd1;
            end else begin
                case (op_q)
                    OP_MULHU, OP_REMU: wb_data_q <= hi_q;
                    default:           wb_data_q <= lo_q;
                endcase
            end
        end
    end

    assign busy    = (state == ST_RUN);
    assign done    = (state == ST_DONE);
    assign wb_we   = done && (wb_reg_q != '0);
    assign wb_reg  = wb_reg_q;
    assign wb_data = wb_data_q;

endmodule
